// File: rtl/pri_arb_2.sv
// Two-client fixed-priority arbiter feeding a one-entry registered memory request stage.
// Client 0 always wins; tagged read responses are steered back combinationally.
module pri_arb_2 #(
   parameter int W  = 16,
   parameter int AW = 10,
   parameter int TW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          client_req_0,
   input  logic [AW-1:0] client_addr_0,
   input  logic          client_read_0,
   input  logic [W-1:0]  client_wdata_0,
   input  logic [TW-1:0] client_tag_0,
   output logic          client_bsy_0,
   input  logic          client_req_1,
   input  logic [AW-1:0] client_addr_1,
   input  logic          client_read_1,
   input  logic [W-1:0]  client_wdata_1,
   input  logic [TW-1:0] client_tag_1,
   output logic          client_bsy_1,
   output logic          client_rvalid_0,
   output logic          client_rvalid_1,
   output logic [W-1:0]  client_rdata,
   output logic [TW-1:0] client_rtag,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   output logic          mem_read,
   output logic [W-1:0]  mem_wdata,
   output logic [TW:0]   mem_tag,
   input  logic          mem_bsy,
   input  logic          mem_rvalid,
   input  logic [W-1:0]  mem_rdata,
   input  logic [TW:0]   mem_rtag
);

   logic          accept;
   logic          mem_req_q,   mem_req_d;
   logic [AW-1:0] mem_addr_q,  mem_addr_d;
   logic          mem_read_q,  mem_read_d;
   logic [W-1:0]  mem_wdata_q, mem_wdata_d;
   logic [TW:0]   mem_tag_q,   mem_tag_d;

   // Stage can take a new request when empty or when its current one drains this cycle.
   assign accept       = ~mem_req_q | ~mem_bsy;
   assign client_bsy_0 = ~accept;
   assign client_bsy_1 = ~accept | client_req_0;

   always_comb begin
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_read_d  = mem_read_q;
      mem_wdata_d = mem_wdata_q;
      mem_tag_d   = mem_tag_q;
      if (accept) begin
         mem_req_d = client_req_0 | client_req_1;
         if (client_req_0) begin
            mem_addr_d  = client_addr_0;
            mem_read_d  = client_read_0;
            mem_wdata_d = client_wdata_0;
            mem_tag_d   = {1'b0, client_tag_0};
         end else if (client_req_1) begin
            mem_addr_d  = client_addr_1;
            mem_read_d  = client_read_1;
            mem_wdata_d = client_wdata_1;
            mem_tag_d   = {1'b1, client_tag_1};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_read_q  <= 1'b0;
         mem_wdata_q <= '0;
         mem_tag_q   <= '0;
      end else begin
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_read_q  <= mem_read_d;
         mem_wdata_q <= mem_wdata_d;
         mem_tag_q   <= mem_tag_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign mem_read  = mem_read_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_tag   = mem_tag_q;

   // Source id in the tag MSB selects which client sees the response.
   assign client_rvalid_0 = mem_rvalid & ~mem_rtag[TW];
   assign client_rvalid_1 = mem_rvalid &  mem_rtag[TW];
   assign client_rdata    = mem_rdata;
   assign client_rtag     = mem_rtag[TW-1:0];

endmodule

// File: tb/tb_pri_arb_2.sv
// Bench for pri_arb_2: directed scenarios plus random traffic, checked against a
// transaction-level model (ordered queue of granted requests) every cycle.
module tb_pri_arb_2;
   localparam int W = 16, AW = 10, TW = 4;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          req0 = 0, rd0 = 0, req1 = 0, rd1 = 0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [W-1:0]  wd0 = '0, wd1 = '0;
   logic [TW-1:0] tag0 = '0, tag1 = '0;
   logic          bsy0, bsy1, rv0, rv1;
   logic [W-1:0]  rdata;
   logic [TW-1:0] rtag;
   logic          mreq, mread;
   logic [AW-1:0] maddr;
   logic [W-1:0]  mwdata;
   logic [TW:0]   mtag;
   logic          mbsy = 0, mrv = 0;
   logic [W-1:0]  mrdata = '0;
   logic [TW:0]   mrtag = '0;

   pri_arb_2 #(.W(W), .AW(AW), .TW(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .client_req_0(req0), .client_addr_0(addr0), .client_read_0(rd0),
      .client_wdata_0(wd0), .client_tag_0(tag0), .client_bsy_0(bsy0),
      .client_req_1(req1), .client_addr_1(addr1), .client_read_1(rd1),
      .client_wdata_1(wd1), .client_tag_1(tag1), .client_bsy_1(bsy1),
      .client_rvalid_0(rv0), .client_rvalid_1(rv1),
      .client_rdata(rdata), .client_rtag(rtag),
      .mem_req(mreq), .mem_addr(maddr), .mem_read(mread), .mem_wdata(mwdata), .mem_tag(mtag),
      .mem_bsy(mbsy), .mem_rvalid(mrv), .mem_rdata(mrdata), .mem_rtag(mrtag));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          rd;
      logic [W-1:0]  wd;
      logic [TW:0]   tag;
   } xfer_t;

   int n_vec = 0, n_err = 0;

   // Model: requests granted by the arbiter wait in order; the head is what memory sees.
   xfer_t pend[$];
   xfer_t last;           // fields last presented to memory (held when idle)
   logic  xf0, xf1;       // client transfers in the cycle just stepped

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic xfer_t dut_view();
      xfer_t x;
      x.addr = maddr; x.rd = mread; x.wd = mwdata; x.tag = mtag;
      return x;
   endfunction

   task automatic model_reset();
      pend.delete();
      last = '0;
   endtask

   // Caller sets inputs just after a falling edge; returns at the next falling edge.
   task automatic step();
      logic busy_stage, e_bsy0, e_bsy1;
      xfer_t x;
      #1;
      busy_stage = (pend.size() != 0) && mbsy;
      e_bsy0 = busy_stage;
      e_bsy1 = busy_stage || req0;
      check("bsy0", bsy0, e_bsy0);
      check("bsy1", bsy1, e_bsy1);
      check("rvalid0", rv0, mrv && (mrtag[TW] == 1'b0));
      check("rvalid1", rv1, mrv && (mrtag[TW] == 1'b1));
      check("rdata", rdata, mrdata);
      check("rtag", rtag, mrtag % (1 << TW));
      check("mem_req", mreq, pend.size() != 0);
      check("mem_fields", dut_view(), (pend.size() != 0) ? pend[0] : last);
      xf0 = req0 && !e_bsy0;
      xf1 = req1 && !e_bsy1;
      if (pend.size() != 0 && !mbsy) void'(pend.pop_front());
      if (xf0) begin
         x.addr = addr0; x.rd = rd0; x.wd = wd0; x.tag = {1'b0, tag0};
         pend.push_back(x); last = x;
      end else if (xf1) begin
         x.addr = addr1; x.rd = rd1; x.wd = wd1; x.tag = {1'b1, tag1};
         pend.push_back(x); last = x;
      end
      check("stage_depth", pend.size() <= 1, 1'b1);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req0 = 0; req1 = 0; mbsy = 0; mrv = 0;
   endtask

   int c0, c1, n1, guard;
   logic [AW-1:0] held_addr;

   initial begin
      model_reset();
      // Reset values and combinational bsy during reset
      req0 = 1;
      #12;
      check("rst_mem_req", mreq, 1'b0);
      check("rst_mem_addr", maddr, '0);
      check("rst_mem_wdata", mwdata, '0);
      check("rst_mem_tag", mtag, '0);
      check("rst_bsy0", bsy0, 1'b0);
      check("rst_bsy1_req0", bsy1, 1'b1);
      req0 = 0;
      #1;
      check("rst_bsy1_idle", bsy1, 1'b0);
      @(negedge clk);
      rst_n = 1;

      // Single client 0 write
      req0 = 1; addr0 = 10'h001; wd0 = 16'h0001; rd0 = 0; tag0 = 4'h0;
      step();
      idle_inputs();
      check("w1_req", mreq, 1'b1);
      check("w1_addr", maddr, 10'h001);
      check("w1_wdata", mwdata, 16'h0001);
      check("w1_read", mread, 1'b0);
      check("w1_tag", mtag, 5'b00000);
      step();
      step();

      // Both clients streaming: client 0 addr 1..15 first, then client 1 addr 33..47
      c0 = 1; c1 = 33; guard = 0;
      while ((c0 <= 15 || c1 <= 47) && guard < 100) begin
         req0 = (c0 <= 15); addr0 = c0[AW-1:0]; wd0 = c0[W-1:0]; tag0 = c0[TW-1:0]; rd0 = 0;
         req1 = (c1 <= 47); addr1 = c1[AW-1:0]; wd1 = c1[W-1:0]; tag1 = c1[TW-1:0]; rd1 = 1;
         step();
         if (xf1) check("c1_after_c0", c0, 16);
         if (xf0) c0++;
         if (xf1) c1++;
         guard++;
      end
      check("stream_done", guard < 100, 1'b1);
      idle_inputs();
      step(); step();

      // Client 0 gated off 2 of every 12 cycles: client 1 gets exactly those slots
      c0 = 0; c1 = 0; n1 = 0;
      for (int cyc = 0; cyc < 36; cyc++) begin
         req0 = (cyc % 12) < 10; addr0 = 10'h100 + c0[AW-1:0]; wd0 = c0[W-1:0]; tag0 = 4'h3;
         req1 = 1; addr1 = 10'h200 + c1[AW-1:0]; wd1 = c1[W-1:0]; tag1 = 4'h5;
         mbsy = 0;
         step();
         if (xf0) c0++;
         if (xf1) begin c1++; n1++; end
      end
      check("gated_c1_slots", n1, 6);
      check("gated_c0_count", c0, 30);
      idle_inputs();
      step(); step();

      // mem_bsy held 3 cycles with a pending request
      req0 = 1; addr0 = 10'h3AA; wd0 = 16'h1234; rd0 = 0; tag0 = 4'h7;
      step();
      held_addr = maddr;
      addr0 = 10'h055; wd0 = 16'h4321;
      mbsy = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("held_addr", maddr, 10'h3AA);
         check("held_bsy1", bsy1, 1'b1);
      end
      mbsy = 0;
      step();
      check("after_release_addr", maddr, 10'h055);
      check("held_captured", held_addr, 10'h3AA);
      idle_inputs();
      step(); step();

      // Tagged read response for client 1, arriving alongside a new client 0 request
      req1 = 1; rd1 = 1; addr1 = 10'h010; tag1 = 4'h9;
      step();
      req1 = 0; req0 = 1; addr0 = 10'h020; rd0 = 1; tag0 = 4'h2;
      mrv = 1; mrtag = 5'b11001; mrdata = 16'hBEEF;
      #1;
      check("resp_rv1", rv1, 1'b1);
      check("resp_rv0", rv0, 1'b0);
      check("resp_rtag", rtag, 4'h9);
      check("resp_rdata", rdata, 16'hBEEF);
      #(-1+1);
      step();
      idle_inputs();
      step();

      // Async reset while the stage is stalled
      req0 = 1; addr0 = 10'h0F0; wd0 = 16'hCAFE;
      step();
      mbsy = 1;
      step();
      check("pre_rst_req", mreq, 1'b1);
      #2 rst_n = 0;
      #1 check("async_rst_req", mreq, 1'b0);
      check("async_rst_addr", maddr, '0);
      model_reset();
      idle_inputs();
      @(negedge clk);
      rst_n = 1;
      step();
      req1 = 1; addr1 = 10'h077; wd1 = 16'h0077; tag1 = 4'h1; rd1 = 0;
      step();
      check("post_rst_tag", mtag, 5'b10001);
      idle_inputs();
      step();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         req0 = ($urandom_range(0, 2) == 0); addr0 = AW'($urandom); rd0 = 1'($urandom);
         wd0 = W'($urandom); tag0 = TW'($urandom);
         req1 = ($urandom_range(0, 1) == 0); addr1 = AW'($urandom); rd1 = 1'($urandom);
         wd1 = W'($urandom); tag1 = TW'($urandom);
         mbsy = ($urandom_range(0, 2) == 0);
         mrv = 1'($urandom); mrtag = (TW+1)'($urandom); mrdata = W'($urandom);
         step();
      end
      idle_inputs();
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end
endmodule
